vram_scanout_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between VGA scanout reads and a game-logic writer.
- Driven by the 640x480 timing generator's hcount/vcount/sync outputs; all logic runs on vga_clock.
- Fetches packed pixel words on a fixed slot schedule, unpacks them into a per-pixel stream, and gives every other RAM cycle to the writer via a ready/req handshake.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/pixel_unpacker.sv | 61 ++++++
 rtl/vram_scanout_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vram_scanout_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480 timing constants, pixel packing factor and scanout FSM state type
// for the VRAM scanout arbiter and its pixel unpacker.
package vga_pkg;

  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int H_START  = 144;
  localparam int V_START  = 35;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // Pixels per RAM word; the fetch schedule assumes exactly one word every four pixels.
  localparam int PPW   = 4;
  localparam int SEL_W = $clog2(PPW);

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pixel_unpacker.sv
// Double-buffered word holder for scanout: next_word catches the RAM word, shift_word
// holds the word being displayed, and one pixel slice is registered per cycle.
module pixel_unpacker
  import vga_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PIX_W  = 4
) (
  input  logic              vga_clock,
  input  logic              reset,
  input  logic              load_next,
  input  logic              load_shift,
  input  logic [DATA_W-1:0] rdata,
  input  logic [SEL_W-1:0]  sel,
  input  logic              blank,
  output logic [PIX_W-1:0]  pixel
);

  logic [DATA_W-1:0] next_word_q;
  logic [DATA_W-1:0] next_word_d;
  logic [DATA_W-1:0] shift_word_q;
  logic [DATA_W-1:0] shift_word_d;
  logic [PIX_W-1:0]  pixel_q;
  logic [PIX_W-1:0]  pixel_d;
  logic [PIX_W-1:0]  slice [PPW];

  // Pixel 0 sits in the least significant bits of the word.
  for (genvar gi = 0; gi < PPW; gi++) begin : g_slice
    assign slice[gi] = shift_word_q[gi*PIX_W +: PIX_W];
  end

  always_comb begin
    next_word_d  = next_word_q;
    shift_word_d = shift_word_q;
    pixel_d      = '0;
    if (load_next) begin
      next_word_d = rdata;
    end
    if (load_shift) begin
      shift_word_d = next_word_q;
    end
    if (!blank) begin
      pixel_d = slice[sel];
    end
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      next_word_q  <= '0;
      shift_word_q <= '0;
      pixel_q      <= '0;
    end else begin
      next_word_q  <= next_word_d;
      shift_word_q <= shift_word_d;
      pixel_q      <= pixel_d;
    end
  end

  assign pixel = pixel_q;

endmodule

// File: rtl/vram_scanout_arbiter.sv
// Shares a single-port video RAM between slot-scheduled scanout fetches and a writer.
// Define VBLANK_WRITE_ONLY_EN to restrict writes to vertical blanking and SYNC.
module vram_scanout_arbiter #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 16,
  parameter int PIX_W    = 4,
  parameter int H_START  = 144,
  parameter int V_START  = 35,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic              vga_clock,
  input  logic              reset,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              at_display_area_in,
  output logic [PIX_W-1:0]  pixel,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              at_display_area_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              frame_locked
);

  import vga_pkg::*;

  // One fetch every PPW pixels, starting PPW cycles ahead of the first visible pixel.
  localparam logic [9:0] FETCH_FIRST = 10'(H_START - PPW);
  localparam logic [9:0] FETCH_LAST  = 10'(H_START + H_ACTIVE - 2*PPW);
  localparam logic [9:0] H_FIRST     = 10'(H_START);
  localparam logic [9:0] V_FIRST     = 10'(V_START);
  localparam logic [9:0] V_END       = 10'(V_START + V_ACTIVE);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] rd_addr_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_we_q;
  logic              mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [2:0]        fetch_pipe_q;
  logic [2:0]        fetch_pipe_d;
  logic              hsync_q;
  logic              hsync_d;
  logic              vsync_q;
  logic              vsync_d;
  logic              disp_q;
  logic              disp_d;

  logic              frame_start;
  logic              v_active;
  logic              fetch_slot;
  logic [SEL_W-1:0]  slot_phase;
  logic [SEL_W-1:0]  pix_sel;
  logic              pix_blank;
  logic              wr_ready_c;

  assign frame_start = (hcount == '0) && (vcount == '0);
  assign v_active    = (vcount >= V_FIRST) && (vcount < V_END);
  assign slot_phase  = SEL_W'(hcount - FETCH_FIRST);
  assign fetch_slot  = (state_q == RUN) && v_active &&
                       (hcount >= FETCH_FIRST) && (hcount <= FETCH_LAST) &&
                       (slot_phase == '0);

  // No grant while reset is held, so a handshake can never be swallowed by it.
  always_comb begin
    wr_ready_c = !reset && !fetch_slot;
`ifdef VBLANK_WRITE_ONLY_EN
    if ((state_q == RUN) && v_active) begin
      wr_ready_c = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    fetch_pipe_d = {fetch_pipe_q[1:0], fetch_slot};
    hsync_d      = hsync_in;
    vsync_d      = vsync_in;
    disp_d       = at_display_area_in;

    if ((state_q == SYNC) && frame_start) begin
      state_d = RUN;
    end

    if (frame_start) begin
      rd_addr_d = '0;
    end else if (fetch_slot) begin
      rd_addr_d = rd_addr_q + ADDR_W'(1);
    end

    // Display owns the port in its slot; the writer takes any other cycle it asks for.
    if (fetch_slot) begin
      mem_addr_d = rd_addr_q;
    end else if (wr_req && wr_ready_c) begin
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
      mem_we_d    = 1'b1;
    end
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state_q      <= SYNC;
      rd_addr_q    <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      fetch_pipe_q <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      disp_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      fetch_pipe_q <= fetch_pipe_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      disp_q       <= disp_d;
    end
  end

  // fetch_pipe_q[1] marks the cycle RAM data is valid, [2] the cycle before display.
  assign pix_sel   = SEL_W'(hcount - H_FIRST);
  assign pix_blank = !at_display_area_in || (state_q != RUN);

  pixel_unpacker #(
    .DATA_W (DATA_W),
    .PIX_W  (PIX_W)
  ) u_unpacker (
    .vga_clock  (vga_clock),
    .reset      (reset),
    .load_next  (fetch_pipe_q[1]),
    .load_shift (fetch_pipe_q[2]),
    .rdata      (mem_rdata),
    .sel        (pix_sel),
    .blank      (pix_blank),
    .pixel      (pixel)
  );

  assign mem_addr            = mem_addr_q;
  assign mem_we              = mem_we_q;
  assign mem_wdata           = mem_wdata_q;
  assign wr_ready            = wr_ready_c;
  assign frame_locked        = (state_q == RUN);
  assign hsync_out           = hsync_q;
  assign vsync_out           = vsync_q;
  assign at_display_area_out = disp_q;

endmodule

// File: tb/tb_vram_scanout_arbiter.sv
// Directed bench for vram_scanout_arbiter: drives a fast-forwarding 800x525 timing
// generator, models the RAM, and scoreboards every cycle's registered outputs.
`timescale 1ns/1ps
module tb_vram_scanout_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;
  localparam int PIX_W  = 4;
`ifdef VBLANK_WRITE_ONLY_EN
  localparam bit VBW = 1'b1;
`else
  localparam bit VBW = 1'b0;
`endif

  typedef enum int {K_RST, K_IDLE, K_FETCH, K_WRITE} kind_t;
  typedef struct {
    kind_t             kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [PIX_W-1:0]  pix;
    logic              hs;
    logic              vs;
    logic              da;
    logic              lock;
  } exp_t;
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              vga_clock;
  logic              reset;
  logic [9:0]        hcount;
  logic [9:0]        vcount;
  logic              hsync_in;
  logic              vsync_in;
  logic              at_display_area_in;
  logic [PIX_W-1:0]  pixel;
  logic              hsync_out;
  logic              vsync_out;
  logic              at_display_area_out;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              frame_locked;

  vram_scanout_arbiter dut (
    .vga_clock           (vga_clock),
    .reset               (reset),
    .hcount              (hcount),
    .vcount              (vcount),
    .hsync_in            (hsync_in),
    .vsync_in            (vsync_in),
    .at_display_area_in  (at_display_area_in),
    .pixel               (pixel),
    .hsync_out           (hsync_out),
    .vsync_out           (vsync_out),
    .at_display_area_out (at_display_area_out),
    .mem_addr            (mem_addr),
    .mem_we              (mem_we),
    .mem_wdata           (mem_wdata),
    .mem_rdata           (mem_rdata),
    .wr_req              (wr_req),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .wr_ready            (wr_ready),
    .frame_locked        (frame_locked)
  );

  initial vga_clock = 1'b0;
  always #5 vga_clock = ~vga_clock;

  function automatic logic [DATA_W-1:0] pat(input int a);
    return DATA_W'((a * 40503) + 7);
  endfunction

  // RAM behind the DUT pins: unwritten words read back the fill pattern.
  logic [DATA_W-1:0] ram       [131072];
  bit                ram_valid [131072];
  always @(posedge vga_clock) begin
    if (mem_we === 1'b1) begin
      ram[mem_addr]       <= mem_wdata;
      ram_valid[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_valid[mem_addr] ? ram[mem_addr] : pat(int'(mem_addr));
  end

  logic [DATA_W-1:0] ram_model [131072];
  bit                mvalid    [131072];
  logic [DATA_W-1:0] line_word [160];
  exp_t              exp_q [$];
  wr_t               wq [$];
  int                h, v, skip_v;
  bit                rst, run_m;
  logic [ADDR_W-1:0] rd_m;
  int                checks, failures, grants_36;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at v=%0d h=%0d", tag, obs, expv, v, h);
    end
  endtask

  task automatic drive_inputs();
    hcount             = 10'(h);
    vcount             = 10'(v);
    hsync_in           = (h >= 96);
    vsync_in           = (v >= 2);
    at_display_area_in = (h >= 144) && (h < 784) && (v >= 35) && (v < 515);
    reset              = rst;
    wr_req             = (wq.size() > 0) && !rst;
    if (wq.size() > 0) begin
      wr_addr = wq[0].addr;
      wr_data = wq[0].data;
    end else begin
      wr_addr = '0;
      wr_data = '0;
    end
  endtask

  task automatic tick();
    exp_t              e;
    bit                fetch, rdy_exp, gnt;
    int                col;
    logic [DATA_W-1:0] w;
    @(negedge vga_clock);
    fetch   = !rst && run_m && (v >= 35) && (v < 515) && (h >= 140) && (h <= 776) && (h % 4 == 0);
    rdy_exp = !fetch && !(VBW && run_m && (v >= 35) && (v < 515));
    if (!rst) chk("wr_ready", wr_ready, rdy_exp);
    gnt    = wr_req && rdy_exp;
    e.kind = K_IDLE;
    e.addr = '0;
    e.data = '0;
    if (rst) begin
      e.kind = K_RST;
    end else if (fetch) begin
      e.kind = K_FETCH;
      e.addr = rd_m;
      line_word[(h - 140) / 4] = mvalid[rd_m] ? ram_model[rd_m] : pat(int'(rd_m));
      rd_m = rd_m + 1'b1;
    end else if (gnt) begin
      e.kind = K_WRITE;
      e.addr = wq[0].addr;
      e.data = wq[0].data;
      ram_model[wq[0].addr] = wq[0].data;
      mvalid[wq[0].addr]    = 1'b1;
      void'(wq.pop_front());
      if (v == 36) grants_36++;
    end
    e.hs   = !rst && hsync_in;
    e.vs   = !rst && vsync_in;
    e.da   = !rst && at_display_area_in;
    e.lock = !rst && (run_m || (h == 0 && v == 0));
    e.pix  = '0;
    if (!rst && run_m && at_display_area_in) begin
      col   = h - 144;
      w     = line_word[col / 4];
      e.pix = w[4*(col % 4) +: 4];
    end
    exp_q.push_back(e);
    if (rst) begin
      run_m = 1'b0;
      rd_m  = '0;
    end else if (h == 0 && v == 0) begin
      run_m = 1'b1;
      rd_m  = '0;
    end

    @(posedge vga_clock);
    #1;
    e = exp_q.pop_front();
    chk("frame_locked", frame_locked, e.lock);
    chk("pixel", pixel, e.pix);
    chk("sync_delay", {hsync_out, vsync_out, at_display_area_out}, {e.hs, e.vs, e.da});
    case (e.kind)
      K_RST: begin
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
      end
      K_FETCH: begin
        chk("fetch_we", mem_we, 0);
        chk("fetch_addr", mem_addr, e.addr);
      end
      K_WRITE: begin
        chk("write_we", mem_we, 1);
        chk("write_addr", mem_addr, e.addr);
        chk("write_data", mem_wdata, e.data);
      end
      default: chk("idle_we", mem_we, 0);
    endcase

    h++;
    if (h == 800) begin
      h = 0;
      if (skip_v >= 0) begin
        v      = skip_v;
        skip_v = -1;
      end else begin
        v = (v + 1) % 525;
      end
    end
    drive_inputs();
  endtask

  task automatic advance_to(input int tv, input int th);
    int n = 0;
    while (!(v == tv && h == th)) begin
      if (n == 5000) begin
        checks++;
        failures++;
        $display("FAIL advance_to timeout observed v=%0d h=%0d expected v=%0d h=%0d", v, h, tv, th);
        return;
      end
      tick();
      n++;
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    grants_36 = 0;
    skip_v    = -1;
    run_m     = 1'b0;
    rd_m      = '0;
    h         = 700;
    v         = 524;
    rst       = 1'b1;
    drive_inputs();

    repeat (4) tick();
    chk("reset_lock", frame_locked, 0);
    chk("reset_pixel", pixel, 0);
    chk("reset_we", mem_we, 0);

    rst = 1'b0;
    wq.push_back('{17'd0,   16'h4321});
    wq.push_back('{17'd159, 16'hFEDC});
    wq.push_back('{17'd160, 16'h8765});
    wq.push_back('{17'd319, 16'h0BAD});
    drive_inputs();

    advance_to(0, 0);
    chk("lock_in_start_cycle", frame_locked, 0);
    tick();
    chk("lock_after_start", frame_locked, 1);

    skip_v = 34;
    advance_to(35, 145);
    for (int i = 0; i < 4; i++) begin
      chk("word0_pixel", pixel, 32'(i + 1));
      tick();
    end
    advance_to(35, 781);
    for (int i = 0; i < 4; i++) begin
      chk("word159_pixel", pixel, 32'(12 + i));
      tick();
    end

    advance_to(36, 0);
    for (int i = 0; i < 800; i++) begin
      wq.push_back('{ADDR_W'(32'h10000 + i), DATA_W'(i ^ 16'h5A5A)});
    end
    drive_inputs();
    advance_to(36, 140);
    #1;
    chk("slot_stall_ready", wr_ready, 0);
    tick();
    #1;
    chk("row1_first_addr", mem_addr, 160);
    chk("row1_first_we", mem_we, 0);
    chk("after_slot_ready", wr_ready, VBW ? 0 : 1);
    advance_to(37, 0);
    chk("line36_grants", grants_36, VBW ? 0 : 640);

    skip_v = 100;
    advance_to(100, 400);
    rst = 1'b1;
    drive_inputs();
    repeat (3) tick();
    rst = 1'b0;
    drive_inputs();
    advance_to(100, 600);
    chk("post_reset_pixel", pixel, 0);
    chk("post_reset_lock", frame_locked, 0);

    skip_v = 524;
    advance_to(0, 0);
    tick();
    chk("relock", frame_locked, 1);
    skip_v = 34;
    advance_to(35, 141);
    chk("refetch_addr", mem_addr, 0);
    chk("refetch_we", mem_we, 0);
    advance_to(35, 145);
    chk("refetch_pixel", pixel, 1);
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
